// File: rtl/pwm_pkg.sv
// Shared constants, button-target encoding and sizing helper for the PWM generator.
package pwm_pkg;

  localparam int CNT_W_DEF     = 10;
  localparam int N_CH_DEF      = 2;
  localparam int DUTY_W_DEF    = 4;
  localparam int FREQ_W_DEF    = 3;
  localparam int FREQ_BASE_DEF = 0;

  typedef enum logic {
    TGT_FREQ = 1'b0,
    TGT_DUTY = 1'b1
  } tgt_e;

  // Select width that never collapses to zero bits for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_gen_param_btn_edge.sv
// Two-flop synchronizer for a raw pushbutton followed by a one-cycle rising-edge pulse.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  // [0],[1] synchronize; [2] is the previous synchronized level for edge detect.
  logic [2:0] sync_pipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[1:0], btn};
  end

  assign pulse = sync_pipe[1] & ~sync_pipe[2];

endmodule

// File: rtl/pwm_gen_param.sv
// Multi-channel phase-interleaved PWM with clock-enable prescaler and
// button-edited duty/frequency settings that go live only at period wrap.
module pwm_gen_param
  import pwm_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int N_CH      = N_CH_DEF,
  parameter int DUTY_W    = DUTY_W_DEF,
  parameter int FREQ_W    = FREQ_W_DEF,
  parameter int FREQ_BASE = FREQ_BASE_DEF
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          ENABLE,
  input  logic                          B_UP,
  input  logic                          B_DOWN,
  input  logic                          E_SWITCH,
  input  logic [clog2_min1(N_CH)-1:0]   CH_SEL,
  output logic [N_CH-1:0]               PWM,
  output logic                          PERIOD_TICK,
  output logic [FREQ_W-1:0]             FREQ_SEL,
  output logic [N_CH*DUTY_W-1:0]        DUTY_LVL
);

  localparam int CH_W = clog2_min1(N_CH);
  localparam int PS_W = FREQ_BASE + (1 << FREQ_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                         up_p, dn_p, inc, dec;
  logic [PS_W-1:0]              ps_cnt, ps_mask;
  logic                         tick;
  logic [CNT_W-1:0]             cnt;
  logic [FREQ_W-1:0]            freq_pend, freq_act;
  logic [N_CH-1:0][DUTY_W-1:0]  duty_pend, duty_act;
  logic [N_CH-1:0]              pwm_nxt;
  tgt_e                         tgt;

  btn_edge u_up (.clk(CLOCK), .rst_n(RESET), .btn(B_UP),   .pulse(up_p));
  btn_edge u_dn (.clk(CLOCK), .rst_n(RESET), .btn(B_DOWN), .pulse(dn_p));

  // Coincident edges cancel.
  assign inc = up_p & ~dn_p;
  assign dec = dn_p & ~up_p;
  assign tgt = tgt_e'(E_SWITCH);

  // Tick when the low FREQ_BASE+FREQ_SEL prescaler bits are all ones.
  assign ps_mask     = ~({PS_W{1'b1}} << (FREQ_BASE + int'(freq_act)));
  assign tick        = &(ps_cnt | ~ps_mask);
  assign PERIOD_TICK = ENABLE & tick & (cnt == CNT_MAX);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      ps_cnt <= '0;
      cnt    <= '0;
    end else if (ENABLE) begin
      ps_cnt <= PERIOD_TICK ? '0 : ps_cnt + PS_W'(1);
      if (tick) cnt <= cnt + CNT_W'(1);
    end
  end

  // Pending settings: saturating button edits.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      freq_pend <= '0;
      duty_pend <= '0;
    end else if (tgt == TGT_FREQ) begin
      if (inc && freq_pend != '1)      freq_pend <= freq_pend + FREQ_W'(1);
      else if (dec && freq_pend != '0) freq_pend <= freq_pend - FREQ_W'(1);
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (CH_SEL == CH_W'(k)) begin
          if (inc && duty_pend[k] != '1)      duty_pend[k] <= duty_pend[k] + DUTY_W'(1);
          else if (dec && duty_pend[k] != '0) duty_pend[k] <= duty_pend[k] - DUTY_W'(1);
        end
      end
    end
  end

  // Active settings follow pending only at wrap, or continuously while stopped.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      freq_act <= '0;
      duty_act <= '0;
    end else if (!ENABLE || PERIOD_TICK) begin
      freq_act <= freq_pend;
      duty_act <= duty_pend;
    end
  end

  assign FREQ_SEL = freq_act;
  assign DUTY_LVL = duty_act;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    localparam logic [CNT_W-1:0] PH_OFS = CNT_W'((longint'(k) << CNT_W) / N_CH);
    logic [CNT_W-1:0] ph_cnt, ref_lvl;
    assign ph_cnt     = cnt + PH_OFS;
    assign ref_lvl    = CNT_W'(duty_act[k]) << (CNT_W - DUTY_W);
    assign pwm_nxt[k] = ENABLE & (ph_cnt < ref_lvl);
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) PWM <= '0;
    else        PWM <= pwm_nxt;
  end

endmodule

// File: tb/tb_pwm_gen_param.sv
// Directed bench for pwm_gen_param at default parameters with a settings scoreboard.
module tb_pwm_gen_param;

  logic       clk = 0, rst_n = 0, en = 0, b_up = 0, b_dn = 0, e_sw = 0;
  logic [0:0] ch_sel = '0;
  logic [1:0] pwm;
  logic       ptick;
  logic [2:0] fsel;
  logic [7:0] dlvl;

  int n_chk = 0, n_fail = 0;
  string       tag_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  pwm_gen_param dut (
    .CLOCK(clk), .RESET(rst_n), .ENABLE(en), .B_UP(b_up), .B_DOWN(b_dn),
    .E_SWITCH(e_sw), .CH_SEL(ch_sel), .PWM(pwm), .PERIOD_TICK(ptick),
    .FREQ_SEL(fsel), .DUTY_LVL(dlvl)
  );

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic sb_pop();
    string t;
    logic [31:0] e;
    if (tag_q.size() == 0) begin
      n_chk++; n_fail++;
      $error("FAIL sb_empty: observed no entry expected one");
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, (t == "freq") ? 32'(fsel) : 32'(dlvl), e);
    end
  endtask

  task automatic press(input bit up, input bit dn);
    b_up = up; b_dn = dn;
    repeat (4) step();
    b_up = 0; b_dn = 0;
    repeat (4) step();
  endtask

  task automatic wait_tick(output int c);
    c = 0;
    do begin step(); c++; end while (!ptick && c < 5000);
    if (!ptick) chk("tick_timeout", 32'(ptick), 1);
  endtask

  task automatic wait_cnt(input int target);
    int c = 0;
    do begin step(); c++; end while (dut.cnt != 10'(target) && c < 5000);
    if (dut.cnt != 10'(target)) chk("cnt_timeout", 32'(dut.cnt), target);
  endtask

  // One full period window; rise indices are relative to the window start.
  task automatic measure(output int h0, output int h1, output int r0, output int r1);
    logic [1:0] prev = pwm;
    h0 = 0; h1 = 0; r0 = -1; r1 = -1;
    for (int i = 0; i < 1024; i++) begin
      step();
      if (pwm[0]) h0++;
      if (pwm[1]) h1++;
      if (pwm[0] && !prev[0] && r0 < 0) r0 = i;
      if (pwm[1] && !prev[1] && r1 < 0) r1 = i;
      prev = pwm;
    end
  endtask

  initial begin
    int c, h0, h1, r0, r1;

    // Reset and idle period
    en = 1;
    repeat (3) step();
    chk("rst_pwm", 32'(pwm), 0);
    chk("rst_fsel", 32'(fsel), 0);
    chk("rst_dlvl", 32'(dlvl), 0);
    chk("rst_ptick", 32'(ptick), 0);
    rst_n = 1;
    wait_tick(c); chk("first_period", c, 1023);
    wait_tick(c); chk("period", c, 1024);

    // 50% duty on both channels, half-period phase offset
    e_sw = 1; ch_sel = 0;
    repeat (8) press(1, 0);
    ch_sel = 1;
    repeat (8) press(1, 0);
    sb_push("duty", 32'h88);
    wait_tick(c); step(); sb_pop();
    measure(h0, h1, r0, r1);
    chk("ch0_high", h0, 512);
    chk("ch1_high", h1, 512);
    chk("phase", r1 - r0, 512);

    // Saturation high then low on ch0
    ch_sel = 0;
    repeat (20) press(1, 0);
    sb_push("duty", 32'h8F);
    wait_tick(c); step(); sb_pop();
    measure(h0, h1, r0, r1);
    chk("sat_hi_ch0", h0, 960);
    repeat (20) press(0, 1);
    sb_push("duty", 32'h80);
    wait_tick(c); step(); sb_pop();
    measure(h0, h1, r0, r1);
    chk("sat_lo_ch0", h0, 0);

    // Simultaneous edges change nothing
    ch_sel = 1; press(1, 1);
    e_sw = 0;   press(1, 1);
    sb_push("duty", 32'h80);
    sb_push("freq", 0);
    wait_tick(c); step(); sb_pop(); sb_pop();

    // Frequency change mid-period
    wait_cnt(300);
    sb_push("freq", 1);
    press(1, 0);
    chk("freq_hold", 32'(fsel), 0);
    wait_tick(c); step(); sb_pop();
    wait_tick(c); chk("slow_period", c, 2047);

    // ENABLE drop at cnt=100 with ch0 at level 2
    e_sw = 1; ch_sel = 0;
    press(1, 0); press(1, 0);
    wait_tick(c);
    wait_cnt(100);
    chk("pre_dis_pwm", 32'(pwm), 2'b01);
    en = 0;
    step();
    chk("dis_pwm", 32'(pwm), 0);
    chk("dis_cnt", 32'(dut.cnt), 100);
    sb_push("duty", 32'h83);
    press(1, 0);
    sb_pop();
    chk("dis_cnt_hold", 32'(dut.cnt), 100);
    chk("dis_pwm_hold", 32'(pwm), 0);
    en = 1;
    step(); chk("resume_cnt0", 32'(dut.cnt), 100);
    step(); chk("resume_cnt1", 32'(dut.cnt), 101);
    chk("resume_pwm", 32'(pwm), 2'b01);

    // Asynchronous reset mid-period
    wait_cnt(700);
    chk("pre_rst_pwm", 32'(pwm), 2'b10);
    rst_n = 0;
    #2;
    chk("arst_pwm", 32'(pwm), 0);
    chk("arst_fsel", 32'(fsel), 0);
    chk("arst_dlvl", 32'(dlvl), 0);
    chk("arst_ptick", 32'(ptick), 0);
    #1 rst_n = 1;
    wait_tick(c); chk("post_rst_period", c, 1023);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
